// File: rtl/mux_pkg.sv
// Shared definitions for the scanning channel multiplexer:
// mode encoding, default geometry and select-width helper.
package mux_pkg;

    localparam logic MODO_MANUAL    = 1'b0;
    localparam logic MODO_VARREDURA = 1'b1;

    localparam int LARGURA_PADRAO = 4;
    localparam int CANAIS_PADRAO  = 4;

    function automatic int selW(input int canais);
        return (canais > 1) ? $clog2(canais) : 1;
    endfunction

endpackage

// File: rtl/mux_n_varredura_arbitro_rr.sv
// Rotating-priority search: first set request at or after
// ponteiro, wrapping from the last channel back to zero.
module arbitro_rr #(
    parameter int CANAIS = 4,
    parameter int SEL_W  = 2
) (
    input  logic [CANAIS-1:0] requisicao,
    input  logic [SEL_W-1:0]  ponteiro,
    output logic [SEL_W-1:0]  concessao,
    output logic              concessaoValida
);

    int pos;

    always_comb begin
        concessao       = '0;
        concessaoValida = 1'b0;
        pos             = 0;
        for (int i = 0; i < CANAIS; i++) begin
            pos = int'(ponteiro) + i;
            if (pos >= CANAIS)
                pos = pos - CANAIS;
            if (!concessaoValida && requisicao[pos]) begin
                concessao       = SEL_W'(pos);
                concessaoValida = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_n_varredura.sv
// N-channel mux with manual or round-robin scan selection and a
// one-word output register; MUX_N_VARREDURA_CONTADOR_EN adds outContagem.
module mux_n_varredura
    import mux_pkg::*;
#(
    parameter  int LARGURA = LARGURA_PADRAO,
    parameter  int CANAIS  = CANAIS_PADRAO,
    localparam int SEL_W   = selW(CANAIS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CANAIS*LARGURA-1:0] inDados,
    input  logic [CANAIS-1:0]         inValido,
    output logic [CANAIS-1:0]         outPronto,
    input  logic                      modo,
    input  logic [SEL_W-1:0]          chaveSeletora,
    output logic [LARGURA-1:0]        outX,
    output logic                      outValido,
    input  logic                      inPronto,
    output logic [SEL_W-1:0]          outCanal
`ifdef MUX_N_VARREDURA_CONTADOR_EN
    ,
    output logic [15:0]               outContagem
`endif
);

    logic [SEL_W-1:0]         ponteiro;
    logic [SEL_W-1:0]         arbIdx;
    logic                     arbOk;
    logic [SEL_W-1:0]         grantIdx;
    logic                     grantOk;
    logic [(1<<SEL_W)-1:0]    canalExiste;
    logic                     livre;
    logic                     aceita;
    logic                     transfIn;
    logic [LARGURA-1:0]       dadoSel;
    logic [SEL_W-1:0]         ponteiroProx;

    arbitro_rr #(
        .CANAIS (CANAIS),
        .SEL_W  (SEL_W)
    ) uArbitro (
        .requisicao      (inValido),
        .ponteiro        (ponteiro),
        .concessao       (arbIdx),
        .concessaoValida (arbOk)
    );

    // Manual indices beyond the last channel grant nothing.
    always_comb begin
        canalExiste = '0;
        for (int i = 0; i < (1 << SEL_W); i++)
            canalExiste[i] = (i < CANAIS);
    end

    always_comb begin
        if (modo == MODO_VARREDURA) begin
            grantIdx = arbIdx;
            grantOk  = arbOk;
        end else begin
            grantIdx = chaveSeletora;
            grantOk  = canalExiste[chaveSeletora];
        end
    end

    assign livre    = !outValido || inPronto;
    assign aceita   = rst_n && livre && grantOk;
    assign transfIn = aceita && inValido[grantIdx];

    always_comb begin
        outPronto = '0;
        dadoSel   = '0;
        for (int k = 0; k < CANAIS; k++) begin
            outPronto[k] = aceita && (grantIdx == SEL_W'(k));
            if (grantIdx == SEL_W'(k))
                dadoSel = inDados[k*LARGURA +: LARGURA];
        end
    end

    assign ponteiroProx = (grantIdx == SEL_W'(CANAIS - 1))
                        ? '0 : grantIdx + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outX      <= '0;
            outCanal  <= '0;
            outValido <= 1'b0;
            ponteiro  <= '0;
        end else if (transfIn) begin
            outX      <= dadoSel;
            outCanal  <= grantIdx;
            outValido <= 1'b1;
            if (modo == MODO_VARREDURA)
                ponteiro <= ponteiroProx;
        end else if (inPronto) begin
            outValido <= 1'b0;
        end
    end

`ifdef MUX_N_VARREDURA_CONTADOR_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            outContagem <= '0;
        else if (outValido && inPronto && (outContagem != 16'hFFFF))
            outContagem <= outContagem + 16'd1;
    end
`endif

endmodule

// File: tb/tb_mux_n_varredura.sv
// Directed and randomized checks of mux_n_varredura against a
// behavioural model; a 3-channel instance covers out-of-range select.
module tb_mux_n_varredura;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] inDados;
    logic [3:0]  inValido;
    logic [3:0]  outPronto;
    logic        modo;
    logic [1:0]  chaveSeletora;
    logic [3:0]  outX;
    logic        outValido;
    logic        inPronto;
    logic [1:0]  outCanal;

    logic [11:0] inDados3;
    logic [2:0]  inValido3;
    logic [2:0]  outPronto3;
    logic        modo3;
    logic [1:0]  chave3;
    logic [3:0]  outX3;
    logic        outValido3;
    logic        inPronto3;
    logic [1:0]  outCanal3;

`ifdef MUX_N_VARREDURA_CONTADOR_EN
    logic [15:0] outContagem;
    logic [15:0] outContagem3;
`endif

    int checks = 0;
    int errors = 0;

    // Reference state
    bit       mValid;
    int       mX;
    int       mCanal;
    int       mPtr;
    int       mCnt;

    always #5 clk = ~clk;

    mux_n_varredura #(.LARGURA(4), .CANAIS(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .inDados       (inDados),
        .inValido      (inValido),
        .outPronto     (outPronto),
        .modo          (modo),
        .chaveSeletora (chaveSeletora),
        .outX          (outX),
        .outValido     (outValido),
        .inPronto      (inPronto),
        .outCanal      (outCanal)
`ifdef MUX_N_VARREDURA_CONTADOR_EN
        ,
        .outContagem   (outContagem)
`endif
    );

    mux_n_varredura #(.LARGURA(4), .CANAIS(3)) dut3 (
        .clk           (clk),
        .rst_n         (rst_n),
        .inDados       (inDados3),
        .inValido      (inValido3),
        .outPronto     (outPronto3),
        .modo          (modo3),
        .chaveSeletora (chave3),
        .outX          (outX3),
        .outValido     (outValido3),
        .inPronto      (inPronto3),
        .outCanal      (outCanal3)
`ifdef MUX_N_VARREDURA_CONTADOR_EN
        ,
        .outContagem   (outContagem3)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Which channel the spec says is offered a slot right now.
    function automatic logic [3:0] expPronto();
        if (!rst_n) return 4'b0;
        if (mValid && !inPronto) return 4'b0;
        if (modo == 1'b0) return 4'b1 << chaveSeletora;
        for (int i = 0; i < 4; i++)
            if (inValido[(mPtr + i) % 4]) return 4'b1 << ((mPtr + i) % 4);
        return 4'b0;
    endfunction

    task automatic step(input string tag);
        logic [3:0] pr;
        int         k;
        bit         t;
        bit         saiu;
        #1;
        pr = expPronto();
        chk({tag, "_pronto"}, 32'(outPronto), 32'(pr));
        t = |(pr & inValido);
        k = 0;
        for (int i = 0; i < 4; i++) if (pr[i]) k = i;
        saiu = mValid && inPronto;
        @(posedge clk);
        if (!rst_n) begin
            mValid = 0; mX = 0; mCanal = 0; mPtr = 0; mCnt = 0;
        end else begin
            if (saiu && mCnt < 65535) mCnt++;
            if (t) begin
                mX = int'(inDados[k*4 +: 4]);
                mCanal = k;
                mValid = 1;
                if (modo) mPtr = (k + 1) % 4;
            end else if (inPronto) begin
                mValid = 0;
            end
        end
        #1;
        chk({tag, "_valido"}, 32'(outValido), 32'(mValid));
        if (mValid || !rst_n) begin
            chk({tag, "_x"}, 32'(outX), 32'(mX));
            chk({tag, "_canal"}, 32'(outCanal), 32'(mCanal));
        end
`ifdef MUX_N_VARREDURA_CONTADOR_EN
        chk({tag, "_contagem"}, 32'(outContagem), 32'(mCnt));
`endif
    endtask

    initial begin
        rst_n = 0; inDados = 16'h4321; inValido = 4'hF; modo = 0;
        chaveSeletora = 0; inPronto = 1;
        inDados3 = 12'hABC; inValido3 = 3'b111; modo3 = 0; chave3 = 2'd3;
        inPronto3 = 1;
        mValid = 0; mX = 0; mCanal = 0; mPtr = 0; mCnt = 0;
        @(posedge clk); #1;
        step("reset0");
        step("reset1");
        chk("reset_valido", 32'(outValido), 32'd0);
        chk("reset_x", 32'(outX), 32'd0);
        rst_n = 1;

        // Manual select of channel 2
        inValido = 4'b0100; chaveSeletora = 2; inDados = 16'h0A00;
        #1;
        chk("man_pronto_const", 32'(outPronto), 32'h4);
        step("man");
        chk("man_x_const", 32'(outX), 32'hA);
        chk("man_canal_const", 32'(outCanal), 32'd2);

        // Full-throughput scan with all channels valid
        modo = 1; inValido = 4'hF; inDados = 16'h8765;
        for (int i = 0; i < 5; i++) begin
            step("scan");
            chk("scan_seq", 32'(outCanal), 32'(i % 4));
            chk("scan_nobubble", 32'(outValido), 32'd1);
        end

        // Pointer wrap: move pointer to 3, then only channel 1 requests
        inValido = 4'b0100; step("ptr_to3");
        inValido = 4'b0010; step("ptr_wrap");
        chk("ptr_wrap_canal", 32'(outCanal), 32'd1);
        inValido = 4'hF; #1;
        chk("ptr_is2", 32'(outPronto), 32'h4);
        step("ptr_after");

        // Back-pressure holds the word
        inPronto = 0;
        for (int i = 0; i < 3; i++) begin
            inValido = 4'(1 << i); inDados = 16'($urandom);
            step("hold");
            chk("hold_pronto", 32'(outPronto), 32'd0);
            chk("hold_canal", 32'(outCanal), 32'd2);
        end
        inPronto = 1; inValido = 4'b0001; inDados = 16'h0005;
        step("release");
        chk("release_x", 32'(outX), 32'h5);

        // Reset discards a held word
        inPronto = 0; step("prerst");
        rst_n = 0; inValido = 4'hF;
        step("rst_held");
        chk("rst_held_valido", 32'(outValido), 32'd0);
        rst_n = 1; inPronto = 1; step("post_rst");
        chk("post_rst_ptr0", 32'(outCanal), 32'd0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            rst_n         = ($urandom_range(0, 49) != 0);
            modo          = 1'($urandom);
            chaveSeletora = 2'($urandom);
            inValido      = 4'($urandom);
            inPronto      = ($urandom_range(0, 3) != 0);
            inDados       = 16'($urandom);
            step("rnd");
        end

        // Three-channel instance: select 3 is out of range
        chk("c3_pronto", 32'(outPronto3), 32'd0);
        chk("c3_valido", 32'(outValido3), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
